// File: rtl/iir_ctrl_if.sv
// iir_ctrl_if: bundle of configuration, upstream, filter-side and downstream
// signals for the IIR filter sequencing controller. Names carry the
// direction as seen from the controller (i_ = into it, o_ = out of it).
interface iir_ctrl_if #(
  parameter int W = 13
);
  logic         i_cfg_we;
  logic [2:0]   i_cfg_addr;
  logic [W-1:0] i_cfg_data;
  logic         o_cfg_busy;

  logic         i_s_valid;
  logic [W-1:0] i_s_data;
  logic         o_s_ready;

  logic         o_f_vin;
  logic [W-1:0] o_f_din;
  logic [W-1:0] o_f_a1;
  logic [W-1:0] o_f_a2;
  logic [W-1:0] o_f_b0;
  logic [W-1:0] o_f_b1;
  logic [W-1:0] o_f_b2;
  logic         o_f_rstn;
  logic         i_f_vout;
  logic [W-1:0] i_f_dout;

  logic         o_m_valid;
  logic [W-1:0] o_m_data;
  logic         o_err;
  logic [15:0]  o_sample_cnt;

  modport master (
    input  i_cfg_we, i_cfg_addr, i_cfg_data, i_s_valid, i_s_data, i_f_vout, i_f_dout,
    output o_cfg_busy, o_s_ready, o_f_vin, o_f_din, o_f_a1, o_f_a2, o_f_b0, o_f_b1,
           o_f_b2, o_f_rstn, o_m_valid, o_m_data, o_err, o_sample_cnt
  );

  modport slave (
    output i_cfg_we, i_cfg_addr, i_cfg_data, i_s_valid, i_s_data, i_f_vout, i_f_dout,
    input  o_cfg_busy, o_s_ready, o_f_vin, o_f_din, o_f_a1, o_f_a2, o_f_b0, o_f_b1,
           o_f_b2, o_f_rstn, o_m_valid, o_m_data, o_err, o_sample_cnt
  );
endinterface

// File: rtl/iir_ctrl.sv
// iir_ctrl: sequencing controller in front of an IIR filter datapath.
// Buffers upstream samples in a small FIFO, paces F_VIN/F_DIN into the
// filter, keeps shadow/active coefficient banks and performs
// drain -> filter reset -> bank swap on a COMMIT write.
// Optional: define IIR_CTRL_SAMPLE_CNT_EN to build the 16-bit returned-sample
// counter; otherwise o_sample_cnt is tied to zero.
module iir_ctrl #(
  parameter int W            = 13,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP          = 0,
  parameter int MAX_OUT      = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_TO     = 64
) (
  input logic         i_clk,
  input logic         i_rst,
  iir_ctrl_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int DW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t       r_state;
  logic [FW-1:0] r_flush_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic [GW-1:0] r_gap;
  logic [OW-1:0] r_outst;
  logic         r_busy, r_f_rstn, r_f_vin, r_err;
  logic [W-1:0] r_f_din;
  logic [W-1:0] r_a1, r_a2, r_b0, r_b1, r_b2;
  logic [W-1:0] r_sh_a1, r_sh_a2, r_sh_b0, r_sh_b1, r_sh_b2;
  logic         r_m_valid;
  logic [W-1:0] r_m_data;

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;

  logic w_empty, w_full, w_push, w_issue, w_cfg_ok, w_commit, w_fwd, w_dec;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push   = bus.i_s_valid && !w_full;
  assign w_issue  = (r_state == ST_RUN) && !w_empty && (r_gap == {GW{1'b0}}) &&
                    (r_outst < OW'(MAX_OUT));
  assign w_cfg_ok = bus.i_cfg_we && !r_busy;
  assign w_commit = w_cfg_ok && (bus.i_cfg_addr == 3'd7);
  // Filter results produced while the filter is held in reset are stale.
  assign w_fwd    = bus.i_f_vout && (r_state != ST_FLUSH);
  assign w_dec    = bus.i_f_vout && (r_outst != {OW{1'b0}});

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.i_s_data;
    end
  end

  // FIFO pointer advance on push and on issue (pop).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Shadow coefficient bank, written only while no commit is in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh_a1 <= {W{1'b0}};
      r_sh_a2 <= {W{1'b0}};
      r_sh_b0 <= {W{1'b0}};
      r_sh_b1 <= {W{1'b0}};
      r_sh_b2 <= {W{1'b0}};
    end else if (w_cfg_ok) begin
      case (bus.i_cfg_addr)
        3'd0:    r_sh_a1 <= bus.i_cfg_data;
        3'd1:    r_sh_a2 <= bus.i_cfg_data;
        3'd2:    r_sh_b0 <= bus.i_cfg_data;
        3'd3:    r_sh_b1 <= bus.i_cfg_data;
        3'd4:    r_sh_b2 <= bus.i_cfg_data;
        default: ;
      endcase
    end
  end

  // Main sequencer: issue pacing, outstanding tracking and FLUSH/RUN/DRAIN flow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= {FW{1'b0}};
      r_drain_cnt <= {DW{1'b0}};
      r_gap       <= {GW{1'b0}};
      r_outst     <= {OW{1'b0}};
      r_busy      <= 1'b1;
      r_f_rstn    <= 1'b0;
      r_f_vin     <= 1'b0;
      r_f_din     <= {W{1'b0}};
      r_err       <= 1'b0;
      r_a1        <= {W{1'b0}};
      r_a2        <= {W{1'b0}};
      r_b0        <= {W{1'b0}};
      r_b1        <= {W{1'b0}};
      r_b2        <= {W{1'b0}};
    end else begin
      r_f_vin <= w_issue;
      if (w_issue) begin
        r_f_din <= r_mem[r_rd_ptr[AW-1:0]];
        r_gap   <= GW'(GAP);
      end else if (r_gap != {GW{1'b0}}) begin
        r_gap <= r_gap - 1'b1;
      end

      case ({w_issue, w_dec})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase

      case (r_state)
        ST_FLUSH: begin
          if (r_flush_cnt == {FW{1'b0}}) begin
            r_a1 <= r_sh_a1;
            r_a2 <= r_sh_a2;
            r_b0 <= r_sh_b0;
            r_b1 <= r_sh_b1;
            r_b2 <= r_sh_b2;
          end
          if (r_flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
            r_state     <= ST_RUN;
            r_f_rstn    <= 1'b1;
            r_busy      <= 1'b0;
            r_flush_cnt <= {FW{1'b0}};
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_commit) begin
            r_state     <= ST_DRAIN;
            r_busy      <= 1'b1;
            r_drain_cnt <= {DW{1'b0}};
          end
        end
        ST_DRAIN: begin
          if (r_outst == {OW{1'b0}}) begin
            r_state     <= ST_FLUSH;
            r_f_rstn    <= 1'b0;
            r_flush_cnt <= {FW{1'b0}};
          end else if (r_drain_cnt == DW'(DRAIN_TO - 1)) begin
            // Filter never returned everything: give up, flag it, start clean.
            r_state     <= ST_FLUSH;
            r_f_rstn    <= 1'b0;
            r_flush_cnt <= {FW{1'b0}};
            r_err       <= 1'b1;
            r_outst     <= {OW{1'b0}};
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_FLUSH;
          r_f_rstn    <= 1'b0;
          r_busy      <= 1'b1;
          r_flush_cnt <= {FW{1'b0}};
        end
      endcase
    end
  end

  // One-register forwarding stage from the filter to the downstream sink.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= {W{1'b0}};
    end else begin
      r_m_valid <= w_fwd;
      if (w_fwd) r_m_data <= bus.i_f_dout;
    end
  end

`ifdef IIR_CTRL_SAMPLE_CNT_EN
  logic [15:0] r_sample_cnt;

  // Free-running count of forwarded samples; only a full reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample_cnt <= 16'd0;
    end else if (w_fwd) begin
      r_sample_cnt <= r_sample_cnt + 16'd1;
    end
  end

  assign bus.o_sample_cnt = r_sample_cnt;
`else
  assign bus.o_sample_cnt = 16'd0;
`endif

  assign bus.o_cfg_busy = r_busy;
  assign bus.o_s_ready  = !w_full;
  assign bus.o_f_vin    = r_f_vin;
  assign bus.o_f_din    = r_f_din;
  assign bus.o_f_a1     = r_a1;
  assign bus.o_f_a2     = r_a2;
  assign bus.o_f_b0     = r_b0;
  assign bus.o_f_b1     = r_b1;
  assign bus.o_f_b2     = r_b2;
  assign bus.o_f_rstn   = r_f_rstn;
  assign bus.o_m_valid  = r_m_valid;
  assign bus.o_m_data   = r_m_data;
  assign bus.o_err      = r_err;
endmodule

// File: tb/tb_iir_ctrl.sv
// tb_iir_ctrl: directed bench for iir_ctrl (GAP=2, MAX_OUT=4, DRAIN_TO=64).
// A small filter stand-in echoes F_VIN/F_DIN three cycles later with
// F_DOUT = F_DIN ^ 0x0055 when echo_en is set.
module tb_iir_ctrl;
  localparam int W = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iir_ctrl_if #(.W(W)) bus ();

  iir_ctrl #(
    .W(W), .FIFO_DEPTH(4), .GAP(2), .MAX_OUT(4), .FLUSH_CYCLES(2), .DRAIN_TO(64)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic echo_en = 1'b0;
  logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0, d2 = '0;

  logic [W-1:0] vin_data[$];
  int           vin_cyc[$];
  logic [W-1:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [W-1:0] d);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_addr = a;
    bus.i_cfg_data = d;
    tick();
    bus.i_cfg_we   = 1'b0;
  endtask

  // Cycle stamp for spacing checks.
  always @(posedge clk) cyc++;

  // Filter stand-in: three-stage echo of the strobe and data.
  always @(posedge clk) begin
    #1;
    bus.i_f_vout = echo_en & p2;
    bus.i_f_dout = d2 ^ 13'h0055;
    p2 = p1; d2 = d1;
    p1 = p0; d1 = d0;
    p0 = bus.o_f_vin; d0 = bus.o_f_din;
  end

  // Record every issued sample and every forwarded result.
  always @(posedge clk) begin
    #1;
    if (bus.o_f_vin === 1'b1) begin
      vin_data.push_back(bus.o_f_din);
      vin_cyc.push_back(cyc);
    end
    if (bus.o_m_valid === 1'b1) m_q.push_back(bus.o_m_data);
  end

  initial begin
    logic rdy;
    logic accepted;
    int   guard;

    bus.i_cfg_we   = 1'b0;
    bus.i_cfg_addr = 3'd0;
    bus.i_cfg_data = '0;
    bus.i_s_valid  = 1'b0;
    bus.i_s_data   = '0;

    // Reset and first flush
    repeat (3) tick();
    check_eq("rst_rstn", bus.o_f_rstn, 0);
    check_eq("rst_busy", bus.o_cfg_busy, 1);
    check_eq("rst_vin", bus.o_f_vin, 0);
    check_eq("rst_mvalid", bus.o_m_valid, 0);
    check_eq("rst_err", bus.o_err, 0);
    check_eq("rst_sready", bus.o_s_ready, 1);
    check_eq("rst_cnt", bus.o_sample_cnt, 0);
    rst = 1'b0;
    tick();
    check_eq("flush1_rstn", bus.o_f_rstn, 0);
    check_eq("flush1_busy", bus.o_cfg_busy, 1);
    tick();
    check_eq("run_rstn", bus.o_f_rstn, 1);
    check_eq("run_busy", bus.o_cfg_busy, 0);
    check_eq("run_a1", bus.o_f_a1, 0);
    check_eq("run_b0", bus.o_f_b0, 0);

    // Coefficient write and commit with nothing outstanding
    cfg_wr(3'd0, 13'h0100);
    check_eq("a1_shadow_only", bus.o_f_a1, 0);
    cfg_wr(3'd2, 13'h0FFF);
    cfg_wr(3'd7, 13'h0000);
    check_eq("commit_busy", bus.o_cfg_busy, 1);
    check_eq("drain_rstn", bus.o_f_rstn, 1);
    check_eq("drain_a1", bus.o_f_a1, 0);
    tick();
    check_eq("flush_rstn", bus.o_f_rstn, 0);
    check_eq("flush_a1_pre", bus.o_f_a1, 0);
    tick();
    check_eq("flush_a1", bus.o_f_a1, 13'h0100);
    check_eq("flush_b0", bus.o_f_b0, 13'h0FFF);
    check_eq("flush2_busy", bus.o_cfg_busy, 1);
    tick();
    check_eq("rerun_rstn", bus.o_f_rstn, 1);
    check_eq("rerun_busy", bus.o_cfg_busy, 0);

    // Ignored writes: unmapped address in RUN, A1 while busy
    cfg_wr(3'd5, 13'h1ABC);
    cfg_wr(3'd7, 13'h0000);
    cfg_wr(3'd0, 13'h1ABC);
    tick();
    tick();
    check_eq("ign_busy", bus.o_cfg_busy, 0);
    check_eq("ign_a1", bus.o_f_a1, 13'h0100);
    check_eq("ign_a2", bus.o_f_a2, 0);
    check_eq("ign_b0", bus.o_f_b0, 13'h0FFF);
    check_eq("ign_b1", bus.o_f_b1, 0);
    check_eq("ign_b2", bus.o_f_b2, 0);

    // Single-sample latency and echo forwarding
    echo_en = 1'b1;
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 13'h0123;
    tick();
    bus.i_s_valid = 1'b0;
    check_eq("lat_vin0", bus.o_f_vin, 0);
    tick();
    check_eq("lat_vin1", bus.o_f_vin, 1);
    check_eq("lat_din", bus.o_f_din, 13'h0123);
    tick();
    check_eq("lat_vin_pulse", bus.o_f_vin, 0);
    repeat (3) tick();
    check_eq("echo_mvalid", bus.o_m_valid, 1);
    check_eq("echo_mdata", bus.o_m_data, 13'h0176);
    tick();
    check_eq("echo_mvalid_off", bus.o_m_valid, 0);

    // Fill with filter silent: pacing, MAX_OUT limit, FIFO full
    echo_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = 13'h0A01 + 13'(i);
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 50) begin
        rdy = bus.o_s_ready;
        tick();
        accepted = rdy;
        guard++;
      end
      check_eq("push_accept", accepted, 1);
    end
    bus.i_s_valid = 1'b0;
    check_eq("fifo_full", bus.o_s_ready, 0);
    repeat (6) tick();
    check_eq("max_out_hold", vin_data.size(), 5);
    check_eq("still_full", bus.o_s_ready, 0);
    if (vin_data.size() >= 5) begin
      check_eq("din_d0", vin_data[1], 13'h0A01);
      check_eq("din_d1", vin_data[2], 13'h0A02);
      check_eq("din_d2", vin_data[3], 13'h0A03);
      check_eq("din_d3", vin_data[4], 13'h0A04);
      check_eq("gap_01", vin_cyc[2] - vin_cyc[1], 3);
      check_eq("gap_12", vin_cyc[3] - vin_cyc[2], 3);
      check_eq("gap_23", vin_cyc[4] - vin_cyc[3], 3);
    end

    // Commit with 4 outstanding: drain timeout after 64 cycles
    cfg_wr(3'd7, 13'h0000);
    check_eq("to_busy", bus.o_cfg_busy, 1);
    repeat (63) tick();
    check_eq("to_err_pre", bus.o_err, 0);
    check_eq("to_rstn_pre", bus.o_f_rstn, 1);
    check_eq("to_no_issue", vin_data.size(), 5);
    tick();
    check_eq("to_err", bus.o_err, 1);
    check_eq("to_rstn", bus.o_f_rstn, 0);
    echo_en = 1'b1;
    tick();
    tick();
    check_eq("to_run_rstn", bus.o_f_rstn, 1);
    check_eq("to_run_busy", bus.o_cfg_busy, 0);
    check_eq("to_a1", bus.o_f_a1, 13'h0100);
    repeat (25) tick();
    check_eq("resume_cnt", vin_data.size(), 9);
    check_eq("fwd_cnt", m_q.size(), 5);
    if (vin_data.size() >= 9) begin
      check_eq("din_d4", vin_data[5], 13'h0A05);
      check_eq("din_d7", vin_data[8], 13'h0A08);
      check_eq("gap_45", vin_cyc[6] - vin_cyc[5], 3);
      check_eq("gap_67", vin_cyc[8] - vin_cyc[7], 3);
    end
    if (m_q.size() >= 5) begin
      check_eq("mdata_d4", m_q[1], 13'h0A50);
      check_eq("mdata_d5", m_q[2], 13'h0A53);
      check_eq("mdata_d6", m_q[3], 13'h0A52);
      check_eq("mdata_d7", m_q[4], 13'h0A5D);
    end
    check_eq("err_sticky", bus.o_err, 1);
    check_eq("drained_ready", bus.o_s_ready, 1);
`ifdef IIR_CTRL_SAMPLE_CNT_EN
    check_eq("sample_cnt", bus.o_sample_cnt, 5);
`else
    check_eq("sample_cnt", bus.o_sample_cnt, 0);
`endif

    // Reset mid-operation
    rst = 1'b1;
    tick();
    check_eq("rst2_err", bus.o_err, 0);
    check_eq("rst2_rstn", bus.o_f_rstn, 0);
    check_eq("rst2_busy", bus.o_cfg_busy, 1);
    check_eq("rst2_a1", bus.o_f_a1, 0);
    check_eq("rst2_cnt", bus.o_sample_cnt, 0);
    rst = 1'b0;
    repeat (2) tick();
    check_eq("rst2_run", bus.o_f_rstn, 1);
    check_eq("rst2_novin", bus.o_f_vin, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
